// File: rtl/commit_trace_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : commit_trace_sequencer
// Description : Buffers commit records in a small FIFO and streams them to the
//               trace sink. Also sequences end-of-run drain and watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module commit_trace_sequencer #(
    parameter int          DEPTH   = 4,
    parameter int unsigned TIMEOUT = 10000,
    parameter logic [31:0] EBREAK  = 32'h00100073
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_inst,
    input  logic [63:0] in_dnpc,
    input  logic        in_kill,
    input  logic        in_invalid,
    output logic [31:0] out_inst,
    output logic [63:0] out_dnpc,
    output logic        out_kill,
    output logic        out_invalid,
    output logic        out_en,
    output logic        halt,
    output logic        abort,
    output logic        timeout,
    output logic [63:0] commit_cnt
);

    localparam int          c_aw      = $clog2(DEPTH);
    localparam logic [31:0] c_timeout = 32'(TIMEOUT);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DRAIN = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t r_state, w_state_nxt;

    // Record layout: {kill, invalid, dnpc, inst}
    logic [97:0]   r_mem [DEPTH];
    logic [c_aw:0] r_wr_ptr, r_rd_ptr;
    logic [31:0]   r_wd;
    logic          r_term_ebreak, r_term_invalid, r_term_timeout;
    logic [31:0]   r_out_inst;
    logic [63:0]   r_out_dnpc;
    logic          r_out_kill, r_out_invalid, r_out_en;
    logic          r_halt, r_abort, r_timeout;
    logic [63:0]   r_commit_cnt;

    logic          w_empty, w_full, w_push, w_pop, w_term, w_expire;
    logic [97:0]   w_head;

    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]) &&
                      (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]);
    assign in_ready = (r_state == S_RUN) && !w_full;
    assign w_push   = in_valid && in_ready;
    assign w_pop    = !w_empty;
    assign w_head   = r_mem[r_rd_ptr[c_aw-1:0]];
    assign w_term   = w_push && !in_kill && ((in_inst == EBREAK) || in_invalid);
    assign w_expire = (TIMEOUT != 0) && (r_state == S_RUN) && (r_wd == c_timeout);

    always_ff @(posedge clock) begin
        if (reset) r_state <= S_RUN;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RUN:   if (w_term || w_expire) w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_empty)            w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_DONE;
            default: w_state_nxt = S_RUN;
        endcase
    end

    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_wr_ptr[c_aw-1:0]] <= {in_kill, in_invalid, in_dnpc, in_inst};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_out_inst    <= '0;
            r_out_dnpc    <= '0;
            r_out_kill    <= 1'b0;
            r_out_invalid <= 1'b0;
            r_out_en      <= 1'b0;
            r_commit_cnt  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            r_out_en <= w_pop;
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                {r_out_kill, r_out_invalid, r_out_dnpc, r_out_inst} <= w_head;
                // Count lands together with the strobe it belongs to
                if (!w_head[97]) r_commit_cnt <= r_commit_cnt + 64'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wd <= '0;
        end else if (r_state == S_RUN) begin
            if (w_push && !in_kill)  r_wd <= '0;
            else if (r_wd != c_timeout) r_wd <= r_wd + 32'd1;
        end
    end

    // A terminal record pushed in the expiry cycle takes precedence over the watchdog
    always_ff @(posedge clock) begin
        if (reset) begin
            r_term_ebreak  <= 1'b0;
            r_term_invalid <= 1'b0;
            r_term_timeout <= 1'b0;
            r_halt         <= 1'b0;
            r_abort        <= 1'b0;
            r_timeout      <= 1'b0;
        end else begin
            if (r_state == S_RUN && (w_term || w_expire)) begin
                r_term_ebreak  <= w_term && (in_inst == EBREAK);
                r_term_invalid <= w_term && in_invalid;
                r_term_timeout <= !w_term;
            end
            if (r_state == S_DRAIN && w_empty) begin
                r_halt    <= r_term_ebreak && !r_term_invalid;
                r_abort   <= r_term_invalid;
                r_timeout <= r_term_timeout;
            end
        end
    end

    assign out_inst    = r_out_inst;
    assign out_dnpc    = r_out_dnpc;
    assign out_kill    = r_out_kill;
    assign out_invalid = r_out_invalid;
    assign out_en      = r_out_en;
    assign halt        = r_halt;
    assign abort       = r_abort;
    assign timeout     = r_timeout;
    assign commit_cnt  = r_commit_cnt;

endmodule
`default_nettype wire

// File: tb/tb_commit_trace_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_commit_trace_sequencer
// Description : Directed self-checking bench for commit_trace_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_commit_trace_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0, in_kill = 1'b0, in_invalid = 1'b0;
    logic [31:0] in_inst = '0;
    logic [63:0] in_dnpc = '0;
    logic        in_ready;
    logic [31:0] out_inst;
    logic [63:0] out_dnpc;
    logic        out_kill, out_invalid, out_en;
    logic        halt, abort, timeout;
    logic [63:0] commit_cnt;

    always #5 clock = ~clock;

    commit_trace_sequencer #(.DEPTH(4), .TIMEOUT(16), .EBREAK(32'h00100073)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_dnpc(in_dnpc), .in_kill(in_kill), .in_invalid(in_invalid),
        .out_inst(out_inst), .out_dnpc(out_dnpc), .out_kill(out_kill),
        .out_invalid(out_invalid), .out_en(out_en),
        .halt(halt), .abort(abort), .timeout(timeout), .commit_cnt(commit_cnt)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc_no = 0;
    logic [31:0] q_inst [$];
    logic        q_kill [$];
    int          q_cyc  [$];

    always @(posedge clock) cyc_no <= cyc_no + 1;

    always @(negedge clock) begin
        if (out_en) begin
            q_inst.push_back(out_inst);
            q_kill.push_back(out_kill);
            q_cyc.push_back(cyc_no);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        in_valid   = 1'b0;
        in_kill    = 1'b0;
        in_invalid = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        q_inst.delete();
        q_kill.delete();
        q_cyc.delete();
    endtask

    task automatic drive(input logic [31:0] inst, input logic [63:0] dnpc,
                         input logic kill, input logic inv);
        in_valid   = 1'b1;
        in_inst    = inst;
        in_dnpc    = dnpc;
        in_kill    = kill;
        in_invalid = inv;
    endtask

    task automatic wait_done(input int lim);
        for (int i = 0; i < lim && !(halt || abort || timeout); i++) step();
        check("done_reached", 64'(halt || abort || timeout), 64'd1);
    endtask

    initial begin
        // Reset state
        step();
        step();
        check("rst_out_en", 64'(out_en), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_inst", 64'(out_inst), 64'd0);
        check("rst_out_dnpc", out_dnpc, 64'd0);
        check("rst_cnt", commit_cnt, 64'd0);
        check("rst_flags", 64'({halt, abort, timeout}), 64'd0);
        reset = 1'b0;

        // Single record, two-cycle latency, one-cycle strobe
        do_reset();
        drive(32'h00000013, 64'h80000004, 1'b0, 1'b0);
        step();
        idle();
        check("t1_no_early_en", 64'(out_en), 64'd0);
        step();
        check("t1_en", 64'(out_en), 64'd1);
        check("t1_inst", 64'(out_inst), 64'h13);
        check("t1_dnpc", out_dnpc, 64'h80000004);
        check("t1_cnt", commit_cnt, 64'd1);
        step();
        check("t1_en_drop", 64'(out_en), 64'd0);
        check("t1_inst_hold", 64'(out_inst), 64'h13);

        // Six back-to-back records, full throughput and order
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(32'h100 + 32'(i), 64'h80000000 + 64'(4 * i), 1'b0, 1'b0);
            check("t2_ready", 64'(in_ready), 64'd1);
            step();
        end
        idle();
        repeat (4) step();
        check("t2_count", 64'(q_inst.size()), 64'd6);
        if (q_inst.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                check("t2_order", 64'(q_inst[i]), 64'(32'h100 + 32'(i)));
                check("t2_consec", 64'(q_cyc[i] - q_cyc[0]), 64'(i));
            end
        end
        check("t2_cnt", commit_cnt, 64'd6);

        // Killed slots are emitted but not counted
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(32'h200 + 32'(i), 64'h0, (i == 1), 1'b0);
            step();
        end
        idle();
        repeat (4) step();
        check("t3_count", 64'(q_inst.size()), 64'd3);
        if (q_kill.size() == 3) check("t3_kills", 64'({q_kill[0], q_kill[1], q_kill[2]}), 64'b010);
        check("t3_cnt", commit_cnt, 64'd2);

        // Halt on ebreak; nothing accepted afterwards
        do_reset();
        drive(32'h300, 64'h0, 1'b0, 1'b0); step();
        drive(32'h301, 64'h0, 1'b0, 1'b0); step();
        drive(32'h00100073, 64'h0, 1'b0, 1'b0); step();
        idle();
        check("t4_ready_drop", 64'(in_ready), 64'd0);
        wait_done(20);
        check("t4_halt", 64'(halt), 64'd1);
        check("t4_abort", 64'(abort), 64'd0);
        check("t4_timeout", 64'(timeout), 64'd0);
        check("t4_emitted", 64'(q_inst.size()), 64'd3);
        if (q_inst.size() == 3) check("t4_last", 64'(q_inst[2]), 64'h00100073);
        check("t4_cnt", commit_cnt, 64'd3);
        drive(32'h3ff, 64'h0, 1'b0, 1'b0);
        repeat (5) step();
        idle();
        check("t4_no_accept", 64'(q_inst.size()), 64'd3);
        check("t4_ready_done", 64'(in_ready), 64'd0);

        // Invalid instruction aborts; invalid beats ebreak on one record
        do_reset();
        drive(32'h00000013, 64'h0, 1'b0, 1'b1); step();
        idle();
        wait_done(20);
        check("t5_abort", 64'(abort), 64'd1);
        check("t5_halt", 64'(halt), 64'd0);
        check("t5_cnt", commit_cnt, 64'd1);
        do_reset();
        drive(32'h00100073, 64'h0, 1'b0, 1'b1); step();
        idle();
        wait_done(20);
        check("t5_prio_abort", 64'(abort), 64'd1);
        check("t5_prio_halt", 64'(halt), 64'd0);

        // Killed ebreak is not terminal
        do_reset();
        drive(32'h00100073, 64'h0, 1'b1, 1'b0); step();
        idle();
        repeat (4) step();
        check("t5_kill_ebreak_ready", 64'(in_ready), 64'd1);
        check("t5_kill_ebreak_halt", 64'(halt), 64'd0);

        // Watchdog with no pushes
        do_reset();
        repeat (15) step();
        check("t6_ready_early", 64'(in_ready), 64'd1);
        repeat (3) step();
        check("t6_ready_late", 64'(in_ready), 64'd0);
        wait_done(10);
        check("t6_timeout", 64'(timeout), 64'd1);
        check("t6_halt_abort", 64'({halt, abort}), 64'd0);

        // Watchdog with only killed pushes
        do_reset();
        drive(32'h13, 64'h0, 1'b1, 1'b0);
        for (int i = 0; i < 40 && !timeout; i++) step();
        idle();
        check("t7_timeout", 64'(timeout), 64'd1);
        check("t7_cnt", commit_cnt, 64'd0);

        // Terminal push in the expiry cycle wins
        do_reset();
        repeat (16) step();
        drive(32'h00100073, 64'h0, 1'b0, 1'b0);
        check("t8_ready", 64'(in_ready), 64'd1);
        step();
        idle();
        wait_done(20);
        check("t8_halt", 64'(halt), 64'd1);
        check("t8_timeout", 64'(timeout), 64'd0);

        // Reset in the middle of a drain
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(32'h400 + 32'(i), 64'h0, 1'b0, 1'b0);
            step();
        end
        drive(32'h00100073, 64'h0, 1'b0, 1'b0); step();
        idle();
        reset = 1'b1;
        step();
        q_inst.delete();
        check("t9_en", 64'(out_en), 64'd0);
        check("t9_inst", 64'(out_inst), 64'd0);
        check("t9_cnt", commit_cnt, 64'd0);
        check("t9_flags", 64'({halt, abort, timeout}), 64'd0);
        reset = 1'b0;
        step();
        check("t9_en_after", 64'(out_en), 64'd0);
        check("t9_ready_after", 64'(in_ready), 64'd1);
        repeat (3) step();
        check("t9_no_pulses", 64'(q_inst.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL sim_timeout: got no finish expected finish");
        $fatal(1, "simulation time limit");
    end

endmodule
`default_nettype wire

// File: doc/commit_trace_sequencer.md
Name: commit_trace_sequencer

Overview:
- Sits between the writeback/commit stage and the instruction-info DPI trace sink.
- Accepts one commit record per cycle over a valid/ready handshake and buffers it in a small FIFO.
- Drains records to the trace sink one per cycle, with the enable asserted for exactly one cycle per record.
- Detects simulation end (ebreak or invalid instruction), sequences the final drain, and runs a no-progress watchdog.

Parameters:
- DEPTH, 4: FIFO entries; power of two, at least 2.
- TIMEOUT, 10000: cycles in RUN with no non-killed commit before timeout fires; 0 disables the watchdog.
- EBREAK, 32'h00100073: instruction encoding treated as the halt trigger.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  commit record present
- in_ready  out  1  sequencer can accept the record
- in_inst  in  32  committed instruction word
- in_dnpc  in  64  next PC after this instruction
- in_kill  in  1  record is a flushed (killed) slot
- in_invalid  in  1  decoder flagged an illegal instruction
- out_inst  out  32  to trace sink
- out_dnpc  out  64  to trace sink
- out_kill  out  1  to trace sink
- out_invalid  out  1  to trace sink
- out_en  out  1  one-cycle strobe, record valid on out_*
- halt  out  1  sticky; ebreak retired
- abort  out  1  sticky; invalid instruction retired
- timeout  out  1  sticky; watchdog expired
- commit_cnt  out  64  number of non-killed records emitted

Behaviour:
- Reset, synchronous: state=RUN, FIFO empty, all out_* = 0, out_en=0, halt/abort/timeout=0, commit_cnt=0, watchdog=0.
- in_ready = (state==RUN) && !full. Push on in_valid && in_ready. Record fields are captured as-is.
- Pop: each cycle the FIFO is non-empty, the head is popped and registered into out_*, with out_en=1 the next cycle.
  - With an empty FIFO, out_en=0 and the out_* data fields hold their last values.
- Latency: a record pushed in cycle N appears with out_en=1 in cycle N+2. Sustained throughput is 1 record/cycle. Order is strictly preserved.
- Push and pop may occur in the same cycle, including at full, where a pop frees a slot only for the next cycle since in_ready uses the registered full flag.
- Pointer widths are log2(DEPTH) plus a wrap bit. Full is defined as equal indices with differing wrap bits.
- Terminal record: a pushed record with in_kill=0 and either (in_inst==EBREAK) or in_invalid=1.
  - Killed records never terminate, never count, and never clear the watchdog.
- States:
  - RUN -> DRAIN: on push of a terminal record, or when the watchdog reaches TIMEOUT (TIMEOUT!=0). in_ready=0 from the following cycle on.
  - DRAIN -> DONE: when the FIFO is empty and no pop is pending, i.e. the last record has been emitted.
  - DONE: absorbing until reset. out_en=0, in_ready=0.
- Flags set on the DRAIN->DONE edge, sticky until reset:
  - halt=1 if the terminal record was ebreak.
  - abort=1 if it was invalid; invalid takes priority if both conditions hold on one record.
  - timeout=1 if entry to DRAIN was caused by the watchdog.
- Watchdog: increments each cycle in RUN. It clears to 0 in any cycle that pushes a non-killed record, and does not advance outside RUN. It saturates at TIMEOUT.
- commit_cnt increments in the same cycle that out_en=1 with out_kill=0. It is 64-bit and wraps modulo 2^64.
- If a terminal push and watchdog expiry occur in the same cycle, the terminal record wins and timeout stays 0.
- Reset asserted mid-DRAIN discards FIFO contents. No out_en is produced in the reset cycle or the cycle after.

Test Plan:
- Single record: reset, then push inst=0x00000013, dnpc=0x80000004 in cycle 2 -> out_en=1 in cycle 4 only, out_inst=0x13, out_dnpc=0x80000004, commit_cnt=1.
- Back-to-back with backpressure: push 6 records continuously with DEPTH=4 -> in_ready never drops below 1 record/cycle of throughput. Six consecutive out_en pulses carry the records in order. commit_cnt=6.
- Killed slots: push 3 records with kill pattern 0,1,0 -> 3 out_en pulses with out_kill=0,1,0. commit_cnt=2.
- Halt: push 2 normal records then inst=0x00100073 -> all 3 emitted, then state DONE, halt=1, in_ready=0. A later in_valid is never accepted.
- Invalid plus watchdog: push invalid=1 -> abort=1, halt=0. Separately, with TIMEOUT=16 and no pushes -> timeout=1 after 16 cycles plus drain. With TIMEOUT=16 and only killed pushes -> timeout still fires.
- Reset mid-drain: fill 3 entries, push ebreak, assert reset during DRAIN -> all outputs return to 0, no further out_en, in_ready=1 one cycle after reset deasserts.
